// File: rtl/count_seq.sv
// Stimulus sequencer and checker for a BW-bit loadable up/down counter.
// Runs load/up/pause/down/load per start pulse and compares cnt_in to a reference model.
module count_seq #(
   parameter int unsigned BW = 10,
   parameter int unsigned LW = 16,
   parameter int unsigned EW = 8
) (
   input  logic          clk5m,
   input  logic          rst,
   input  logic          start,
   input  logic [BW-1:0] start_val,
   input  logic [BW-1:0] end_val,
   input  logic [LW-1:0] up_len,
   input  logic [LW-1:0] pause_len,
   input  logic [LW-1:0] dn_len,
   input  logic [BW-1:0] cnt_in,
   output logic [BW-1:0] data_in,
   output logic          load,
   output logic          en,
   output logic          updn,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [EW-1:0] err_cnt
);

   typedef enum logic [2:0] {
      StIdle, StLoad, StUp, StPause, StDown, StFinal, StDone
   } state_e;

   state_e        state_q, state_d;
   logic [LW-1:0] phase_q, phase_d;

   logic [BW-1:0] sv_q, ev_q, exp_q;
   logic [LW-1:0] up_q, pause_q, dn_q;
   logic          chk_q, err_q;
   logic [EW-1:0] err_cnt_q;

   // State register, including the shared phase down-counter
   always_ff @(posedge clk5m) begin
      if (rst) begin
         state_q <= StIdle;
         phase_q <= '0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
      end
   end

   // Next state; zero-length phases are skipped by looking ahead at the latched lengths
   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      unique case (state_q)
         StIdle:  if (start) state_d = StLoad;
         StLoad:  state_d = (up_q != '0)    ? StUp :
                            (pause_q != '0) ? StPause :
                            (dn_q != '0)    ? StDown : StFinal;
         StUp: begin
            if (phase_q == '0) begin
               state_d = (pause_q != '0) ? StPause : (dn_q != '0) ? StDown : StFinal;
            end else begin
               phase_d = phase_q - 1'b1;
            end
         end
         StPause: begin
            if (phase_q == '0) state_d = (dn_q != '0) ? StDown : StFinal;
            else               phase_d = phase_q - 1'b1;
         end
         StDown: begin
            if (phase_q == '0) state_d = StFinal;
            else               phase_d = phase_q - 1'b1;
         end
         StFinal: state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
      // Reload the phase counter on every state entry
      if (state_d != state_q) begin
         case (state_d)
            StUp:    phase_d = up_q - 1'b1;
            StPause: phase_d = pause_q - 1'b1;
            StDown:  phase_d = dn_q - 1'b1;
            default: phase_d = '0;
         endcase
      end
   end

   // Outputs decoded from the current state
   always_comb begin
      data_in = '0;
      load    = 1'b0;
      en      = 1'b0;
      updn    = 1'b0;
      done    = 1'b0;
      busy    = (state_q != StIdle);
      unique case (state_q)
         StLoad: begin
            load    = 1'b1;
            data_in = sv_q;
         end
         StUp:   en = 1'b1;
         StDown: begin
            en   = 1'b1;
            updn = 1'b1;
         end
         StFinal: begin
            load    = 1'b1;
            data_in = ev_q;
         end
         StDone:  done = 1'b1;
         default: ;
      endcase
   end

   // Sequence parameters, reference model and checker
   always_ff @(posedge clk5m) begin
      if (rst) begin
         sv_q      <= '0;
         ev_q      <= '0;
         up_q      <= '0;
         pause_q   <= '0;
         dn_q      <= '0;
         exp_q     <= '0;
         chk_q     <= 1'b0;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         if (state_q == StIdle && start) begin
            sv_q      <= start_val;
            ev_q      <= end_val;
            up_q      <= up_len;
            pause_q   <= pause_len;
            dn_q      <= dn_len;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
         end
         case (state_q)
            StLoad: begin
               exp_q <= sv_q;
               chk_q <= 1'b1;
            end
            StUp:    exp_q <= exp_q + 1'b1;
            StDown:  exp_q <= exp_q - 1'b1;
            StFinal: exp_q <= ev_q;
            StDone:  chk_q <= 1'b0;
            default: ;
         endcase
         // chk_q is never set in IDLE, so this cannot collide with the clear on start
         if (chk_q && (cnt_in != exp_q)) begin
            err_q <= 1'b1;
            if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
         end
      end
   end

   assign err     = err_q;
   assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_count_seq.sv
// Self-checking bench for count_seq: behavioural counter, per-cycle output scoreboard,
// error injection, zero lengths, saturation and mid-sequence reset.
module tb_count_seq;
   localparam int BW = 10;
   localparam int LW = 16;
   localparam int EW = 8;

   logic          clk5m = 1'b0;
   logic          rst, start;
   logic [BW-1:0] start_val, end_val, cnt_in, data_in;
   logic [LW-1:0] up_len, pause_len, dn_len;
   logic          load, en, updn, busy, done, err;
   logic [EW-1:0] err_cnt;

   logic [BW-1:0] cnt_model = '0;
   logic [BW-1:0] inj_val;
   logic          inj;
   logic [BW+4:0] obs_vec;
   logic [BW+4:0] sb[$];

   int n_tests = 0;
   int n_fail  = 0;

   always #100 clk5m = ~clk5m;

   count_seq #(.BW(BW), .LW(LW), .EW(EW)) dut (
      .clk5m(clk5m), .rst(rst), .start(start), .start_val(start_val), .end_val(end_val),
      .up_len(up_len), .pause_len(pause_len), .dn_len(dn_len), .cnt_in(cnt_in),
      .data_in(data_in), .load(load), .en(en), .updn(updn), .busy(busy), .done(done),
      .err(err), .err_cnt(err_cnt)
   );

   // The counter under check: load has priority over enable, wraps both ways
   always_ff @(posedge clk5m) begin
      if (load)    cnt_model <= data_in;
      else if (en) cnt_model <= updn ? cnt_model - 1'b1 : cnt_model + 1'b1;
   end

   assign cnt_in  = inj ? inj_val : cnt_model;
   assign obs_vec = {busy, load, en, updn, done, data_in};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_n(input logic [BW+4:0] v, input int n);
      repeat (n) sb.push_back(v);
   endtask

   // One sequence; expected {busy,load,en,updn,done,data_in} per cycle is queued up front
   task automatic run_seq(input logic [BW-1:0] sv, input logic [BW-1:0] ev,
                          input logic [LW-1:0] u, input logic [LW-1:0] p,
                          input logic [LW-1:0] d, input bit restart,
                          input logic exp_err, input int exp_ec);
      logic [BW+4:0] v;
      logic [BW-1:0] up_end, dn_end;
      int            i;
      up_end = sv + u[BW-1:0];
      dn_end = up_end - d[BW-1:0];
      push_n({5'b11000, sv}, 1);
      push_n({5'b10100, {BW{1'b0}}}, int'(u));
      push_n({5'b10000, {BW{1'b0}}}, int'(p));
      push_n({5'b10110, {BW{1'b0}}}, int'(d));
      push_n({5'b11000, ev}, 1);
      push_n({5'b10001, {BW{1'b0}}}, 1);
      push_n('0, 2);
      @(posedge clk5m); #1;
      start_val = sv; end_val = ev; up_len = u; pause_len = p; dn_len = d;
      start = 1'b1;
      @(posedge clk5m); #1;
      start = restart;
      i = 0;
      while (sb.size() > 0) begin
         @(negedge clk5m);
         v = sb.pop_front();
         check("trace", obs_vec, v);
         if (!inj && i == 1 + int'(u)) check("cnt_after_up", cnt_model, up_end);
         if (!inj && i == 1 + int'(u) + int'(p) + int'(d)) check("cnt_after_down", cnt_model, dn_end);
         if (!inj && i == 2 + int'(u) + int'(p) + int'(d)) check("cnt_after_final", cnt_model, ev);
         i++;
         @(posedge clk5m); #1;
         start = 1'b0;
      end
      check("err", err, exp_err);
      check("err_cnt", err_cnt, exp_ec);
   endtask

   initial begin
      #(200 * 40000);
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; start = 1'b0; inj = 1'b0; inj_val = '0;
      start_val = '0; end_val = '0; up_len = '0; pause_len = '0; dn_len = '0;
      repeat (2) @(posedge clk5m);
      @(negedge clk5m);
      check("reset_outputs", obs_vec, 0);
      check("reset_err", err, 1'b0);
      check("reset_err_cnt", err_cnt, 0);
      @(posedge clk5m); #1;
      rst = 1'b0;

      // Nominal sequence: 73 busy cycles, cnt 50 / 25 / 0
      run_seq(10'd10, 10'd0, 16'd40, 16'd5, 16'd25, 1'b0, 1'b0, 0);
      // Wrap in both directions
      run_seq(10'd1020, 10'd5, 16'd6, 16'd0, 16'd4, 1'b0, 1'b0, 0);

      // Stuck counter: mismatches in UP cycles 2-4 and FINAL
      inj = 1'b1; inj_val = 10'd10;
      run_seq(10'd10, 10'd10, 16'd4, 16'd0, 16'd0, 1'b0, 1'b1, 4);
      repeat (3) @(posedge clk5m);
      @(negedge clk5m);
      check("err_sticky", err, 1'b1);
      check("err_cnt_sticky", err_cnt, 4);

      // Zero-length phases, with a start pulse during busy that must be ignored
      inj = 1'b0;
      run_seq(10'd7, 10'd3, 16'd0, 16'd0, 16'd0, 1'b1, 1'b0, 0);

      // 300 mismatches saturate the count at 255
      inj = 1'b1; inj_val = 10'd0;
      run_seq(10'd0, 10'd0, 16'd300, 16'd0, 16'd0, 1'b0, 1'b1, 255);

      // Reset in the middle of UP after an injected mismatch
      inj = 1'b1; inj_val = 10'd10;
      @(posedge clk5m); #1;
      start_val = 10'd10; end_val = 10'd0; up_len = 16'd40; pause_len = 16'd5; dn_len = 16'd25;
      start = 1'b1;
      @(posedge clk5m); #1;
      start = 1'b0;
      repeat (10) @(posedge clk5m);
      @(negedge clk5m);
      check("mid_up_busy", busy, 1'b1);
      check("mid_up_err", err, 1'b1);
      @(posedge clk5m); #1;
      rst = 1'b1;
      @(posedge clk5m); #1;
      rst = 1'b0;
      @(negedge clk5m);
      check("rst_mid_outputs", obs_vec, 0);
      check("rst_mid_err", err, 1'b0);
      check("rst_mid_err_cnt", err_cnt, 0);
      inj = 1'b0;
      run_seq(10'd10, 10'd0, 16'd40, 16'd5, 16'd25, 1'b0, 1'b0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
